// File: rtl/fram_spi_reader.sv
// SPI mode-0 burst reader for the configuration FRAM (READ 0x03, 16-bit address).
// One request in flight plus one pending slot; one byte per valid pulse.
module fram_spi_reader #(
  parameter int         CLK_DIV      = 4,
  parameter int         CS_SETUP_CYC = 2,
  parameter int         CS_HOLD_CYC  = 2,
  parameter int         CS_GAP_CYC   = 4,
  parameter logic [7:0] CMD_READ     = 8'h03
) (
  input  logic        sys_clk,
  input  logic        glbl_rst,
  input  logic        afpga_fram_rden,
  input  logic [10:0] afpga_fram_length,
  input  logic [15:0] afpga_fram_addr,
  output logic        init_fram_valid,
  output logic        init_fram_last,
  output logic [7:0]  init_fram_data,
  output logic        fram_busy,
  output logic        req_drop,
  output logic        fram_cs_n,
  output logic        fram_sclk,
  output logic        fram_mosi,
  input  logic        fram_miso
);

  localparam int TMAX = 2 * CLK_DIV + CS_SETUP_CYC
                      + CS_HOLD_CYC + CS_GAP_CYC;
  localparam int CW = $clog2(TMAX + 1);

  localparam logic [CW-1:0] SAMPLE_AT = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HIGH_AT   = CW'(CLK_DIV);
  localparam logic [CW-1:0] BIT_END   = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_END = CW'(CS_SETUP_CYC - 1);
  localparam logic [CW-1:0] HOLD_END  = CW'(CLK_DIV + CS_HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_END   = CW'(CS_GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_CA,
    S_DATA,
    S_HOLD,
    S_GAP
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [4:0]  bit_q;
  logic [4:0]  bit_n;
  logic [10:0] byte_q;
  logic [10:0] byte_n;
  logic [10:0] len_q;
  logic [10:0] len_last;
  logic [23:0] tx;
  logic [23:0] tx_n;
  logic [7:0]  rx;
  logic        rdy;
  logic        rden_d;
  logic        req;
  logic        req_ok;
  logic        start;
  logic        pend_v;
  logic [15:0] pend_addr;
  logic [10:0] pend_len;
  logic [15:0] start_addr;
  logic [10:0] start_len;
  logic        sample;
  logic        shift_n;

  assign len_last   = len_q - 11'd1;
  assign req        = afpga_fram_rden & ~rden_d;
  assign req_ok     = req & (afpga_fram_length != 11'd0);
  assign start_addr = pend_v ? pend_addr : afpga_fram_addr;
  assign start_len  = pend_v ? pend_len : afpga_fram_length;
  assign sample     = (state == S_DATA) && (cnt == SAMPLE_AT);
  assign shift_n    = (state_n == S_CA) || (state_n == S_DATA);

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    bit_n   = bit_q;
    byte_n  = byte_q;
    start   = 1'b0;
    unique case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (pend_v || req_ok) begin
          start   = 1'b1;
          state_n = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt == SETUP_END) begin
          state_n = S_CA;
          cnt_n   = '0;
          bit_n   = 5'd0;
        end
      end
      S_CA: begin
        if (cnt == BIT_END) begin
          cnt_n = '0;
          if (bit_q == 5'd23) begin
            state_n = S_DATA;
            bit_n   = 5'd0;
            byte_n  = 11'd0;
          end else begin
            bit_n = bit_q + 5'd1;
          end
        end
      end
      S_DATA: begin
        if (cnt == BIT_END) begin
          cnt_n = '0;
          if (bit_q == 5'd7) begin
            bit_n = 5'd0;
            if (byte_q == len_last) begin
              state_n = S_HOLD;
            end else begin
              byte_n = byte_q + 11'd1;
            end
          end else begin
            bit_n = bit_q + 5'd1;
          end
        end
      end
      S_HOLD: begin
        if (cnt == HOLD_END) begin
          state_n = S_GAP;
          cnt_n   = '0;
        end
      end
      S_GAP: begin
        if (cnt == GAP_END) begin
          cnt_n = '0;
          // a request arriving on the exit cycle is visible here
          if (pend_v || req_ok) begin
            start   = 1'b1;
            state_n = S_SETUP;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    tx_n = tx;
    if (start) begin
      tx_n = {CMD_READ, start_addr};
    end else if (state == S_CA && cnt == BIT_END) begin
      tx_n = {tx[22:0], 1'b0};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (glbl_rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      bit_q           <= 5'd0;
      byte_q          <= 11'd0;
      len_q           <= 11'd0;
      tx              <= 24'd0;
      rx              <= 8'd0;
      rdy             <= 1'b0;
      rden_d          <= 1'b0;
      pend_v          <= 1'b0;
      pend_addr       <= 16'd0;
      pend_len        <= 11'd0;
      init_fram_valid <= 1'b0;
      init_fram_last  <= 1'b0;
      init_fram_data  <= 8'd0;
      fram_busy       <= 1'b0;
      req_drop        <= 1'b0;
      fram_cs_n       <= 1'b1;
      fram_sclk       <= 1'b0;
      fram_mosi       <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      bit_q  <= bit_n;
      byte_q <= byte_n;
      tx     <= tx_n;
      rden_d <= afpga_fram_rden;
      if (start) begin
        len_q <= start_len;
      end
      if (req_ok && !pend_v && !start) begin
        pend_v    <= 1'b1;
        pend_addr <= afpga_fram_addr;
        pend_len  <= afpga_fram_length;
      end else if (start && pend_v) begin
        pend_v <= 1'b0;
      end
      req_drop  <= req_ok & pend_v;
      fram_cs_n <= (state_n == S_IDLE) || (state_n == S_GAP);
      fram_sclk <= shift_n && (cnt_n >= HIGH_AT);
      fram_mosi <= (state_n == S_CA) ? tx_n[23] : 1'b0;
      fram_busy <= (state_n != S_IDLE);
      if (sample) begin
        rx <= {rx[6:0], fram_miso};
      end
      // byte is complete one cycle after its 8th sample
      rdy             <= sample && (bit_q == 5'd7);
      init_fram_valid <= rdy;
      init_fram_last  <= rdy && (byte_q == len_last);
      if (rdy) begin
        init_fram_data <= rx;
      end
    end
  end

endmodule

// File: tb/tb_fram_spi_reader.sv
// Bench for fram_spi_reader: FRAM slave model backed by a memory array,
// scoreboard of expected bytes/commands, cycle-accurate latency checks.
module tb_fram_spi_reader;

  logic        sys_clk = 1'b0;
  logic        glbl_rst;
  logic        rden;
  logic [10:0] len;
  logic [15:0] addr;
  logic        init_fram_valid;
  logic        init_fram_last;
  logic [7:0]  init_fram_data;
  logic        fram_busy;
  logic        req_drop;
  logic        fram_cs_n;
  logic        fram_sclk;
  logic        fram_mosi;
  logic        fram_miso = 1'b0;

  fram_spi_reader dut (
    .sys_clk           (sys_clk),
    .glbl_rst          (glbl_rst),
    .afpga_fram_rden   (rden),
    .afpga_fram_length (len),
    .afpga_fram_addr   (addr),
    .init_fram_valid   (init_fram_valid),
    .init_fram_last    (init_fram_last),
    .init_fram_data    (init_fram_data),
    .fram_busy         (fram_busy),
    .req_drop          (req_drop),
    .fram_cs_n         (fram_cs_n),
    .fram_sclk         (fram_sclk),
    .fram_mosi         (fram_mosi),
    .fram_miso         (fram_miso)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic [7:0]  mem [0:65535];
  exp_t        exp_q[$];
  logic [23:0] cmd_q[$];
  int          vcyc[$];
  int          cs_lo[$];
  int          cs_hi[$];
  int          cyc = 0;
  int          n_valid = 0;
  int          n_drop = 0;
  int          n_bfall = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          sbit = 0;
  logic [23:0] scmd = 24'd0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  // FRAM slave: latch 24 command bits on rising SCLK, shift data on falling
  initial forever begin
    @(negedge fram_cs_n);
    sbit = 0;
    scmd = 24'd0;
  end

  initial forever begin
    @(posedge fram_sclk);
    if (!fram_cs_n) begin
      if (sbit < 24) begin
        scmd = {scmd[22:0], fram_mosi};
        if (sbit == 23) begin
          if (cmd_q.size() == 0) check("cmd_unexp", scmd, 0);
          else check("mosi_cmd", scmd, cmd_q.pop_front());
        end
      end
      sbit++;
    end
  end

  initial forever begin
    logic [15:0] a;
    logic [7:0]  b;
    int          idx;
    @(negedge fram_sclk);
    if (!fram_cs_n && sbit >= 24) begin
      idx = sbit - 24;
      a = scmd[15:0] + 16'(idx / 8);
      b = mem[a];
      fram_miso = b[7 - (idx % 8)];
    end
  end

  // output monitor and scoreboard
  initial begin
    logic cs_prev;
    logic b_prev;
    exp_t e;
    cs_prev = 1'b1;
    b_prev  = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (init_fram_valid === 1'b1) begin
        n_valid++;
        vcyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("extra_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("data", init_fram_data, e.d);
          check("last", init_fram_last, e.l);
        end
      end else if (init_fram_last === 1'b1) begin
        check("last_no_valid", 1, 0);
      end
      if (req_drop === 1'b1) n_drop++;
      if (cs_prev && fram_cs_n === 1'b0) cs_lo.push_back(cyc);
      if (!cs_prev && fram_cs_n === 1'b1) cs_hi.push_back(cyc);
      if (b_prev && fram_busy === 1'b0) n_bfall++;
      cs_prev = (fram_cs_n !== 1'b0);
      b_prev  = (fram_busy === 1'b1);
    end
  end

  task automatic issue(input logic [15:0] a, input logic [10:0] n,
                       input bit acc, input int hold, output int t);
    @(posedge sys_clk);
    #1;
    addr = a;
    len  = n;
    rden = 1'b1;
    t    = cyc;
    repeat (hold) begin
      @(posedge sys_clk);
      #1;
    end
    rden = 1'b0;
    addr = 16'($urandom);
    len  = 11'($urandom);
    if (acc) begin
      cmd_q.push_back({8'h03, a});
      for (int i = 0; i < int'(n); i++) begin
        exp_q.push_back({mem[a + 16'(i)], i == int'(n) - 1});
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    do begin
      @(negedge sys_clk);
      k++;
    end while (fram_busy && k < budget);
    check("idle_timeout", fram_busy, 0);
  endtask

  task automatic wait_last(input int budget);
    int k = 0;
    do begin
      @(negedge sys_clk);
      k++;
    end while (!init_fram_last && k < budget);
    check("last_timeout", init_fram_last, 1);
  endtask

  initial begin
    int t0, t1, t2, bv, bl, bh, bd, bf, k;
    logic [15:0] ra;
    logic [10:0] rn;
    glbl_rst = 1'b1;
    rden = 1'b0;
    len  = 11'd0;
    addr = 16'd0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0400] = 8'hA5;
    mem[16'h0401] = 8'h3C;
    mem[16'h0402] = 8'h0F;
    mem[16'h0403] = 8'hF0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_cs_n", fram_cs_n, 1);
    check("rst_sclk", fram_sclk, 0);
    check("rst_mosi", fram_mosi, 0);
    check("rst_valid", init_fram_valid, 0);
    check("rst_last", init_fram_last, 0);
    check("rst_data", init_fram_data, 0);
    check("rst_busy", fram_busy, 0);
    check("rst_drop", req_drop, 0);
    @(posedge sys_clk);
    #1 glbl_rst = 1'b0;
    repeat (3) @(posedge sys_clk);

    // basic burst, queued follow-up, dropped third request
    issue(16'h0400, 11'd4, 1, 1, t0);
    wait_last(600);
    issue(16'h0800, 11'd2, 1, 1, t1);
    issue(16'h0C00, 11'd3, 0, 1, t2);
    wait_idle(1500);
    check("first_valid", vcyc[0], t0 + 256);
    for (int i = 1; i < 4; i++) check("byte_gap", vcyc[i] - vcyc[i-1], 64);
    check("cs_low_t", cs_lo[0], t0 + 1);
    check("cs_high_t", cs_hi[0], t0 + 457);
    check("cs_gap", cs_lo[1] - cs_hi[0], 4);
    check("n_bursts", cs_lo.size(), 2);
    check("n_valid12", n_valid, 6);
    check("drop_cyc", n_drop, 1);
    check("busy_cont", n_bfall, 1);

    // reset during the second data byte drops burst and pending slot
    issue(16'($urandom), 11'd4, 1, 1, t0);
    bv = n_valid;
    repeat (10) @(posedge sys_clk);
    issue(16'($urandom), 11'd3, 1, 1, t1);
    k = 0;
    while (n_valid == bv && k < 600) begin
      @(negedge sys_clk);
      k++;
    end
    check("rst_first_v", n_valid, bv + 1);
    repeat (20) @(posedge sys_clk);
    #1 glbl_rst = 1'b1;
    @(posedge sys_clk);
    #1 glbl_rst = 1'b0;
    exp_q.delete();
    cmd_q.delete();
    @(negedge sys_clk);
    check("mid_rst_cs", fram_cs_n, 1);
    check("mid_rst_sclk", fram_sclk, 0);
    check("mid_rst_busy", fram_busy, 0);
    bv = n_valid;
    bl = cs_lo.size();
    repeat (400) @(negedge sys_clk);
    check("post_rst_v", n_valid, bv);
    check("post_rst_cs", cs_lo.size(), bl);
    issue(16'($urandom), 11'd3, 1, 1, t0);
    wait_idle(800);
    check("clean_burst", n_valid, bv + 3);

    // zero length is a silent no-op
    bv = n_valid;
    bl = cs_lo.size();
    bd = n_drop;
    bf = n_bfall;
    issue(16'h1234, 11'd0, 0, 1, t0);
    repeat (60) @(negedge sys_clk);
    check("len0_cs", cs_lo.size(), bl);
    check("len0_busy", fram_busy, 0);
    check("len0_bfall", n_bfall, bf);
    check("len0_valid", n_valid, bv);
    check("len0_drop", n_drop, bd);

    // random bursts, some with a queued follow-up, plus address wrap
    for (int r = 0; r < 5; r++) begin
      ra = (r == 0) ? 16'hFFFE : 16'($urandom);
      rn = (r == 0) ? 11'd4 : 11'($urandom_range(1, 5));
      bv = n_valid;
      issue(ra, rn, 1, 1, t0);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 100)) @(posedge sys_clk);
        issue(16'($urandom), 11'd2, 1, 1, t1);
        rn = rn + 11'd2;
      end
      wait_idle(2000);
      check("rand_count", n_valid, bv + int'(rn));
    end

    // long burst; rden held for three cycles is a single request
    bv = n_valid;
    bl = cs_lo.size();
    bh = cs_hi.size();
    bd = n_drop;
    issue(16'h0400, 11'd1024, 1, 3, t0);
    wait_idle(70000);
    check("long_count", n_valid, bv + 1024);
    check("long_cs_lo", cs_lo.size(), bl + 1);
    check("long_cs_hi", cs_hi.size(), bh + 1);
    check("long_drop", n_drop, bd);

    check("exp_left", exp_q.size(), 0);
    check("cmd_left", cmd_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
